cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
Sequences the single shared multi-cycle main memory between the I-cache miss path, the D-cache miss path and D-side write-through stores. On a grant it issues a 16-byte block fill as 8 consecutive word reads, or a single word write. It steers returned data to the owning cache with a word index. It sits between both caches and the memory model; the pipeline stalls while either cache waits on it.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, memory word width
WORDS_PER_BLOCK, 8, words per cache block (power of 2; word = 2 bytes)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_miss_req  in  1  I-cache miss, level, held until i_fill_done
i_miss_addr  in  ADDR_W  I-cache miss byte address
d_miss_req  in  1  D-cache miss, level, held until d_fill_done
d_miss_addr  in  ADDR_W  D-cache miss byte address
d_wr_req  in  1  write-through store, level, held until d_wr_ack
d_wr_addr  in  ADDR_W  store byte address
d_wr_data  in  DATA_W  store data
mem_enable  out  1  memory request this cycle
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_rvalid  in  1  mem_rdata valid (fixed memory latency, pipelined)
fill_data  out  DATA_W  mem_rdata passthrough
fill_word  out  log2(WORDS_PER_BLOCK)  word index of fill_data within block
i_fill_we  out  1  write fill_data into I-cache line
d_fill_we  out  1  write fill_data into D-cache line
i_fill_done  out  1  one-cycle pulse: I fill complete
d_fill_done  out  1  one-cycle pulse: D fill complete
d_wr_ack  out  1  one-cycle pulse: store issued
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, counters 0, owner none. All outputs 0 except passthrough fill_data.
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, WRITE, FILL_ISSUE, FILL_DRAIN, DONE.
- Outputs are Moore-decoded from state and counters, except the *_fill_we strobes and fill_data.
- IDLE grant priority, fixed: d_wr_req > d_miss_req > i_miss_req.
- At grant, the arbiter latches owner, address (block base = addr with low 4 bits cleared) and write data. Later requester input changes are ignored until completion.
- IDLE -> WRITE: in WRITE, mem_enable=1, mem_wr=1, mem_addr=latched d_wr_addr, mem_wdata=latched data, d_wr_ack=1. Next state IDLE. The write occupies 1 cycle.
- IDLE -> FILL_ISSUE: one read per cycle, mem_enable=1, mem_wr=0. mem_addr = {base[15:4], issue_idx, 1'b0}. issue_idx increments modulo 8. After the 8th issue -> FILL_DRAIN.
- FILL_ISSUE and FILL_DRAIN: each mem_rvalid asserts the owner's *_fill_we, presents fill_word = ret_idx, and increments ret_idx.
- On the 8th return -> DONE. Data may return while still in FILL_ISSUE.
- DONE: pulse the owner's *_fill_done for 1 cycle, then go to IDLE.
- The requester drops req in the cycle after done or ack. IDLE re-arbitrates one cycle later, so there is no back-to-back grant to the same stale request.
- Timing: request seen in IDLE at cycle t, memory latency L. Issues occur t+1..t+8; returns t+1+L..t+8+L; done at t+9+L.
- mem_rvalid in IDLE, WRITE or DONE is ignored: no we, no counter change.
- Simultaneous requests: only the highest priority is granted; the others wait and remain asserted.
- Reset mid-operation returns to IDLE immediately. Reads still in flight are discarded by the ignore rule above, and no done pulse is produced.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: issue_idx and ret_idx start at miss_addr[3:1] and wrap modulo 8, with the 8 issues ending at start-1. fill_word reports the true index.
- Undefined: both counters start at 0 and ignore miss_addr[3:1].

Decomposition:
- Package cache_arb_pkg: state enum, owner enum (NONE/I/D), WORD_IDX_W, BLOCK_OFFSET_W constants.
- One sub-module block_word_counter: loadable 3-bit wrapping counter with done flag at 8 counts. It is instanced twice, for issue and return.

Test Plan:
- I-miss only, addr 0x1236, L=4, request seen at t=0: issues 0x1230..0x123E at t=1..8, i_fill_we t=5..12 with fill_word 0..7, i_fill_done pulse t=13. With CRITICAL_WORD_FIRST_EN: first issue 0x1236, fill_word order 3,4,5,6,7,0,1,2.
- d_miss_req and i_miss_req rise in the same cycle: D fill completes first with d_fill_we only. The I fill starts in the IDLE cycle after d_fill_done.
- d_wr_req addr 0x0040, data 0xBEEF: the next cycle has mem_enable=1, mem_wr=1, mem_addr 0x0040, mem_wdata 0xBEEF, d_wr_ack=1, and busy drops the cycle after.
- d_wr_req together with d_miss_req: WRITE is granted first, then the D fill.
- rst asserted during FILL_ISSUE at the 3rd issue: the next cycle is IDLE with all outputs 0. Late mem_rvalid pulses produce no fill_we, and no done pulse occurs.
- Spurious mem_rvalid in IDLE: no we, counters unchanged, and the following fill still returns fill_word 0..7.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and constants for the cache fill arbiter:
//   arb_state_e     - arbiter FSM states
//   owner_e         - which requester currently owns the memory
//   WORDS_PER_BLOCK - default words per cache block (power of 2)
//   WORD_IDX_W      - width of a word index within a block
//   BLOCK_OFFSET_W  - width of the byte offset within a block
// ---------------------------------------------------------------------------
package cache_arb_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
  // Words are 2 bytes, so the byte offset is one bit wider than the word index.
  localparam int BLOCK_OFFSET_W  = WORD_IDX_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL_ISSUE,
    ST_FILL_DRAIN,
    ST_DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter_if
// Request/response bus between the arbiter and the shared main memory.
//   mem_enable  - memory request this cycle
//   mem_wr      - 1 = write, 0 = read
//   mem_addr    - byte address
//   mem_wdata   - write data
//   mem_rdata   - read data
//   mem_rvalid  - mem_rdata valid (fixed latency, pipelined)
// Modports: master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface cache_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_enable, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_enable, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );

endinterface

// File: rtl/block_word_counter.sv
// ---------------------------------------------------------------------------
// block_word_counter
// Loadable wrapping word-index counter for one block transfer.
//   clk, rst  - clock, synchronous active-high reset
//   load      - start a new block: idx <= load_val, step count cleared
//   load_val  - first word index of the block
//   inc       - advance idx by one (wraps modulo 2**WIDTH)
//   idx       - current word index
//   last      - high while the count about to be taken is the final one
//               of the block (2**WIDTH counts since load)
// ---------------------------------------------------------------------------
module block_word_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] idx,
  output logic             last
);

  logic [WIDTH-1:0] idx_q;
  // Counts increments since load independently of idx, so a non-zero start
  // index still terminates after exactly one full block.
  logic [WIDTH-1:0] steps_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      steps_q <= '0;
    end else if (load) begin
      idx_q   <= load_val;
      steps_q <= '0;
    end else if (inc) begin
      idx_q   <= idx_q + 1'b1;
      steps_q <= steps_q + 1'b1;
    end
  end

  assign idx  = idx_q;
  assign last = &steps_q;

endmodule

// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
// Shares one multi-cycle main memory between the I-cache miss path, the
// D-cache miss path and D-side write-through stores. A miss is served as a
// block fill of WORDS_PER_BLOCK consecutive word reads; a store as one write.
// Fixed grant priority: d_wr_req > d_miss_req > i_miss_req.
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   i_miss_req/i_miss_addr    - I-cache miss (level, held until i_fill_done)
//   d_miss_req/d_miss_addr    - D-cache miss (level, held until d_fill_done)
//   d_wr_req/addr/data        - write-through store (held until d_wr_ack)
//   mem                       - memory bus (cache_fill_arbiter_if.master)
//   fill_data                 - mem_rdata passthrough
//   fill_word                 - word index of fill_data within the block
//   i_fill_we / d_fill_we     - write fill_data into the owner's line
//   i_fill_done / d_fill_done - one-cycle fill-complete pulses
//   d_wr_ack                  - one-cycle pulse: store issued
//   busy                      - arbiter not idle
//
// Build option: define CRITICAL_WORD_FIRST_EN to start each fill at the
// missing word (miss_addr word bits) and wrap around the block; otherwise
// fills always start at word 0.
// ---------------------------------------------------------------------------
module cache_fill_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = cache_arb_pkg::WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_miss_req,
  input  logic [ADDR_W-1:0]                  i_miss_addr,
  input  logic                               d_miss_req,
  input  logic [ADDR_W-1:0]                  d_miss_addr,
  input  logic                               d_wr_req,
  input  logic [ADDR_W-1:0]                  d_wr_addr,
  input  logic [DATA_W-1:0]                  d_wr_data,
  cache_fill_arbiter_if.master               mem,
  output logic [DATA_W-1:0]                  fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               i_fill_we,
  output logic                               d_fill_we,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               d_wr_ack,
  output logic                               busy
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W = IDX_W + 1;

  arb_state_e        state_q, state_d;
  owner_e            owner_q;
  // Holds the full granted address; fills drop the block offset when the
  // read address is built, so the same register serves stores and fills.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              grant_wr, grant_d, grant_i, grant_fill;
  logic [ADDR_W-1:0] sel_miss_addr;
  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  issue_idx, ret_idx;
  logic              issue_last, ret_last;
  logic              issue_fire, ret_fire, fill_phase;

  // ---------------- arbitration ----------------
  assign grant_wr      = (state_q == ST_IDLE) && d_wr_req;
  assign grant_d       = (state_q == ST_IDLE) && !d_wr_req && d_miss_req;
  assign grant_i       = (state_q == ST_IDLE) && !d_wr_req && !d_miss_req && i_miss_req;
  assign grant_fill    = grant_d || grant_i;
  assign sel_miss_addr = grant_d ? d_miss_addr : i_miss_addr;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_idx = sel_miss_addr[OFF_W-1:1];
`else
  assign start_idx = '0;
`endif

  // Returns count only while a fill is in progress; a stray or late
  // mem_rvalid (e.g. reads in flight across a reset) is dropped here.
  assign fill_phase = (state_q == ST_FILL_ISSUE) || (state_q == ST_FILL_DRAIN);
  assign issue_fire = (state_q == ST_FILL_ISSUE);
  assign ret_fire   = fill_phase && mem.mem_rvalid;

  block_word_counter #(.WIDTH(IDX_W)) u_issue_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_fill),
    .load_val (start_idx),
    .inc      (issue_fire),
    .idx      (issue_idx),
    .last     (issue_last)
  );

  block_word_counter #(.WIDTH(IDX_W)) u_ret_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (grant_fill),
    .load_val (start_idx),
    .inc      (ret_fire),
    .idx      (ret_idx),
    .last     (ret_last)
  );

  // ---------------- state and grant registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant_wr) begin
        owner_q <= OWN_D;
        addr_q  <= d_wr_addr;
        wdata_q <= d_wr_data;
      end else if (grant_fill) begin
        owner_q <= grant_d ? OWN_D : OWN_I;
        addr_q  <= sel_miss_addr;
      end else if (state_q == ST_WRITE || state_q == ST_DONE) begin
        owner_q <= OWN_NONE;
      end
    end
  end

  // ---------------- next state ----------------
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_wr)        state_d = ST_WRITE;
        else if (grant_fill) state_d = ST_FILL_ISSUE;
      end
      ST_WRITE:      state_d = ST_IDLE;
      ST_FILL_ISSUE: begin
        // Returns can overlap issuing, so the final return is checked first.
        if (ret_fire && ret_last) state_d = ST_DONE;
        else if (issue_last)      state_d = ST_FILL_DRAIN;
      end
      ST_FILL_DRAIN: begin
        if (ret_fire && ret_last) state_d = ST_DONE;
      end
      ST_DONE:       state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    mem.mem_enable = 1'b0;
    mem.mem_wr     = 1'b0;
    mem.mem_addr   = '0;
    mem.mem_wdata  = '0;
    d_wr_ack       = 1'b0;
    unique case (state_q)
      ST_WRITE: begin
        mem.mem_enable = 1'b1;
        mem.mem_wr     = 1'b1;
        mem.mem_addr   = addr_q;
        mem.mem_wdata  = wdata_q;
        d_wr_ack       = 1'b1;
      end
      ST_FILL_ISSUE: begin
        mem.mem_enable = 1'b1;
        mem.mem_addr   = {addr_q[ADDR_W-1:OFF_W], issue_idx, 1'b0};
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign fill_data   = mem.mem_rdata;
  assign fill_word   = fill_phase ? ret_idx : '0;
  assign i_fill_we   = ret_fire && (owner_q == OWN_I);
  assign d_fill_we   = ret_fire && (owner_q == OWN_D);
  assign i_fill_done = (state_q == ST_DONE) && (owner_q == OWN_I);
  assign d_fill_done = (state_q == ST_DONE) && (owner_q == OWN_D);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_arbiter
// Directed bench for cache_fill_arbiter with a 4-cycle pipelined memory
// model whose read data is (address ^ 16'h5A5A). Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// Fill timing relative to the first busy cycle (k = 1): issues k = 1..8,
// fill strobes k = 5..12, done pulse k = 13, idle again at k = 14.
// ---------------------------------------------------------------------------
module tb_cache_fill_arbiter;

  logic        clk;
  logic        rst;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

  int n_vec = 0;
  int n_err = 0;

  cache_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mif ();

  cache_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss_req  (i_miss_req),
    .i_miss_addr (i_miss_addr),
    .d_miss_req  (d_miss_req),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem         (mif),
    .fill_data   (fill_data),
    .fill_word   (fill_word),
    .i_fill_we   (i_fill_we),
    .d_fill_we   (d_fill_we),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_ack    (d_wr_ack),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 4-stage read pipeline, not reset by rst so that reads in
  // flight across a reset still come back.
  bit   [3:0]  pv;
  logic [15:0] pa [4];
  bit          spur;

  always @(posedge clk) begin
    pv    <= {pv[2:0], mif.mem_enable === 1'b1 && mif.mem_wr === 1'b0};
    pa[0] <= mif.mem_addr;
    for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
  end

  assign mif.mem_rvalid = pv[3] | spur;
  assign mif.mem_rdata  = pa[3] ^ 16'h5A5A;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Runs one complete fill. The request must already be visible; exp_wait
  // is the number of idle samples expected before the first busy sample.
  task automatic do_fill(input bit is_d, input logic [15:0] addr,
                         input int exp_wait, input string tag);
    int          w;
    int          start;
    logic [2:0]  wi;
    logic [15:0] ea;
    logic        own_we, oth_we, own_done;
    start = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'(addr[3:1]);
`endif
    w = 0;
    @(negedge clk);
    while (busy !== 1'b1 && w < 40) begin
      w++;
      @(negedge clk);
    end
    n_vec++;
    if (w !== exp_wait) begin
      n_err++;
      $display("FAIL %s grant_wait: got %0d idle cycles, expected %0d", tag, w, exp_wait);
    end
    if (w >= 40) begin
      if (is_d) d_miss_req = 1'b0; else i_miss_req = 1'b0;
      return;
    end
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      own_we   = is_d ? d_fill_we   : i_fill_we;
      oth_we   = is_d ? i_fill_we   : d_fill_we;
      own_done = is_d ? d_fill_done : i_fill_done;
      n_vec++;
      if (mif.mem_enable !== (k <= 8)) begin
        n_err++;
        $display("FAIL %s mem_enable k=%0d: got %b expected %b", tag, k, mif.mem_enable, k <= 8);
      end
      if (k <= 8) begin
        wi = 3'(start + k - 1);
        ea = {addr[15:4], wi, 1'b0};
        n_vec++;
        if (mif.mem_addr !== ea || mif.mem_wr !== 1'b0) begin
          n_err++;
          $display("FAIL %s issue k=%0d: got addr %h wr %b expected addr %h wr 0",
                   tag, k, mif.mem_addr, mif.mem_wr, ea);
        end
      end
      n_vec++;
      if (own_we !== (k >= 5 && k <= 12) || oth_we !== 1'b0) begin
        n_err++;
        $display("FAIL %s fill_we k=%0d: got own %b other %b expected own %b other 0",
                 tag, k, own_we, oth_we, k >= 5 && k <= 12);
      end
      if (k >= 5 && k <= 12) begin
        wi = 3'(start + k - 5);
        ea = {addr[15:4], wi, 1'b0} ^ 16'h5A5A;
        n_vec++;
        if (fill_word !== wi || fill_data !== ea) begin
          n_err++;
          $display("FAIL %s return k=%0d: got word %0d data %h expected word %0d data %h",
                   tag, k, fill_word, fill_data, wi, ea);
        end
      end
      n_vec++;
      if (own_done !== (k == 13) || busy !== (k <= 13)) begin
        n_err++;
        $display("FAIL %s done/busy k=%0d: got done %b busy %b expected done %b busy %b",
                 tag, k, own_done, busy, k == 13, k <= 13);
      end
      if (k == 13) begin
        if (is_d) d_miss_req = 1'b0; else i_miss_req = 1'b0;
      end
    end
  endtask

  // Checks the single WRITE cycle that follows the grant of a visible store.
  task automatic do_write(input logic [15:0] addr, input logic [15:0] data,
                          input string tag);
    @(negedge clk);
    n_vec++;
    if (mif.mem_enable !== 1'b1 || mif.mem_wr !== 1'b1 || d_wr_ack !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s write_ctl: got en %b wr %b ack %b busy %b expected 1 1 1 1",
               tag, mif.mem_enable, mif.mem_wr, d_wr_ack, busy);
    end
    n_vec++;
    if (mif.mem_addr !== addr || mif.mem_wdata !== data) begin
      n_err++;
      $display("FAIL %s write_bus: got addr %h data %h expected addr %h data %h",
               tag, mif.mem_addr, mif.mem_wdata, addr, data);
    end
    d_wr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({mif.mem_enable, mif.mem_wr, i_fill_we, d_fill_we, i_fill_done, d_fill_done,
         d_wr_ack, busy} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b expected 00000000",
               {mif.mem_enable, mif.mem_wr, i_fill_we, d_fill_we, i_fill_done, d_fill_done,
                d_wr_ack, busy});
    end
    n_vec++;
    if (mif.mem_addr !== 16'h0 || mif.mem_wdata !== 16'h0 || fill_word !== 3'd0) begin
      n_err++;
      $display("FAIL reset_bus: got addr %h wdata %h word %0d expected 0 0 0",
               mif.mem_addr, mif.mem_wdata, fill_word);
    end
    rst = 1'b0;
  endtask

  task automatic test_i_fill();
    i_miss_addr = 16'h1236;
    i_miss_req  = 1'b1;
    do_fill(1'b0, 16'h1236, 0, "i_fill");
  endtask

  task automatic test_priority();
    d_miss_addr = 16'h2104;
    i_miss_addr = 16'h1236;
    d_miss_req  = 1'b1;
    i_miss_req  = 1'b1;
    do_fill(1'b1, 16'h2104, 0, "prio_d");
    // I starts in the IDLE cycle right after d_fill_done.
    do_fill(1'b0, 16'h1236, 0, "prio_i");
  endtask

  task automatic test_write();
    d_wr_addr = 16'h0040;
    d_wr_data = 16'hBEEF;
    d_wr_req  = 1'b1;
    do_write(16'h0040, 16'hBEEF, "write");
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || d_wr_ack !== 1'b0 || mif.mem_enable !== 1'b0) begin
      n_err++;
      $display("FAIL write_after: got busy %b ack %b en %b expected 0 0 0",
               busy, d_wr_ack, mif.mem_enable);
    end
  endtask

  task automatic test_write_over_miss();
    d_wr_addr   = 16'h0050;
    d_wr_data   = 16'h1234;
    d_miss_addr = 16'h4448;
    d_wr_req    = 1'b1;
    d_miss_req  = 1'b1;
    do_write(16'h0050, 16'h1234, "wr_first");
    do_fill(1'b1, 16'h4448, 1, "wr_then_dfill");
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] ea;
    int          start;
    start = 0;
`ifdef CRITICAL_WORD_FIRST_EN
    start = 2;
`endif
    i_miss_addr = 16'h3004;
    i_miss_req  = 1'b1;
    repeat (3) @(negedge clk);
    ea = {12'h300, 3'(start + 2), 1'b0};
    n_vec++;
    if (mif.mem_enable !== 1'b1 || mif.mem_addr !== ea) begin
      n_err++;
      $display("FAIL rst_mid third_issue: got en %b addr %h expected en 1 addr %h",
               mif.mem_enable, mif.mem_addr, ea);
    end
    rst        = 1'b1;
    i_miss_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mif.mem_enable, mif.mem_wr, i_fill_we, i_fill_done, busy} !== 5'b0 ||
        mif.mem_addr !== 16'h0 || fill_word !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid outputs: got en %b wr %b we %b done %b busy %b addr %h word %0d expected all 0",
               mif.mem_enable, mif.mem_wr, i_fill_we, i_fill_done, busy, mif.mem_addr, fill_word);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if (i_fill_we !== 1'b0 || i_fill_done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid late_return c=%0d: got we %b done %b busy %b expected 0 0 0",
                 c, i_fill_we, i_fill_done, busy);
      end
    end
  endtask

  task automatic test_spurious_rvalid();
    spur = 1'b1;
    #1;
    n_vec++;
    if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL spurious_idle: got i_we %b d_we %b busy %b expected 0 0 0",
               i_fill_we, d_fill_we, busy);
    end
    @(negedge clk);
    spur        = 1'b0;
    d_miss_addr = 16'h2000;
    d_miss_req  = 1'b1;
    do_fill(1'b1, 16'h2000, 0, "post_spurious");
  endtask

  initial begin
    i_miss_req  = 1'b0;
    d_miss_req  = 1'b0;
    d_wr_req    = 1'b0;
    i_miss_addr = 16'h0;
    d_miss_addr = 16'h0;
    d_wr_addr   = 16'h0;
    d_wr_data   = 16'h0;
    spur        = 1'b0;
    test_reset();
    @(negedge clk);
    test_i_fill();
    test_priority();
    @(negedge clk);
    test_write();
    test_write_over_miss();
    @(negedge clk);
    test_reset_mid_fill();
    test_spurious_rvalid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
